sprite_fetch_engine: RTL and testbench

Requesting side of the sprite ROM interface. On a start command, it streams all word addresses of one sprite into the sprite ROM block and captures the fixed-latency read data. The words are handed downstream, with their addresses, over a valid/ready stream that tolerates backpressure. Sits between the frame/scanline renderer (consumer) and the sprite ROM (responder). Credit-based issue guarantees no returned ROM word is ever dropped, even though the ROM cannot stall.

---
 rtl/sprite_fetch_engine.sv | 174 +++++++++++++++++
 tb/tb_sprite_fetch_engine.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_fetch_engine.sv
// Sprite ROM fetch engine: streams every word address of one sprite into a
// fixed-latency ROM and forwards the returned words downstream over a
// valid/ready stream. Issue is credit-limited so the return FIFO can never
// overflow, even though the ROM itself cannot be stalled.
module sprite_fetch_engine #(
  parameter int unsigned ROM_LATENCY = 3,
  parameter int unsigned WORDS       = 1024,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned ADDR_W      = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [2:0]        sprite_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [2:0]        rom_sprite_sel_o,
  output logic [ADDR_W-1:0] rom_word_addr_o,
  input  logic [15:0]       rom_data_i,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic [15:0]       word_data_o,
  output logic [ADDR_W-1:0] word_addr_o,
  output logic              word_last_o
);

  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EntryW = 1 + ADDR_W + 16;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [2:0]             sel_q, sel_d;
  logic [ROM_LATENCY-1:0] issue_q, issue_d;
  logic [ADDR_W-1:0]      ret_addr_q, ret_addr_d;
  logic                   done_q, done_d;

  logic [EntryW-1:0]      mem [FIFO_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        cnt_q;

  logic [31:0]            inflight;
  logic [EntryW-1:0]      head;
  logic                   fifo_empty, fifo_full;
  logic                   push, pop;
  logic                   credit_ok, accept, issue, last_addr, ret_last, finish;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(FIFO_DEPTH - 1)) return '0;
    return p + PtrW'(1);
  endfunction

  // Count words issued to the ROM whose data has not yet come back.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LATENCY; i++) begin
      inflight = inflight + {31'd0, issue_q[i]};
    end
  end

  // Handshake, credit and return-path decode.
  always_comb begin
    head       = mem[rd_ptr_q];
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == CntW'(FIFO_DEPTH));
    pop        = !fifo_empty && word_ready_i;
    push       = issue_q[ROM_LATENCY-1];
    // Credits count this cycle's pop, so a freed slot is reusable at once.
    credit_ok  = (inflight + 32'(cnt_q) - {31'd0, pop}) < FIFO_DEPTH;
    accept     = (state_q == StIdle) && start_i && (sprite_i != 3'd7);
    issue      = (state_q == StFetch) && credit_ok;
    last_addr  = (addr_q == ADDR_W'(WORDS - 1));
    ret_last   = (ret_addr_q == ADDR_W'(WORDS - 1));
    finish     = (state_q == StDrain) && pop && head[EntryW-1] &&
                 (cnt_q == CntW'(1)) && (issue_q == '0);
  end

  // Next-state logic for the fetch sequencer.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    done_d     = 1'b0;
    issue_d    = (issue_q << 1) | ROM_LATENCY'(issue);
    ret_addr_d = push ? ret_addr_q + ADDR_W'(1) : ret_addr_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sel_d      = sprite_i;
          addr_d     = '0;
          ret_addr_d = '0;
          state_d    = StFetch;
        end
      end
      StFetch: begin
        if (issue) begin
          // Hold at the final address rather than wrapping into a second pass.
          if (last_addr) state_d = StDrain;
          else           addr_d  = addr_q + ADDR_W'(1);
        end
      end
      StDrain: begin
        if (finish) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state, ROM request registers and issue shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      sel_q      <= '0;
      issue_q    <= '0;
      ret_addr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      issue_q    <= issue_d;
      ret_addr_q <= ret_addr_d;
      done_q     <= done_d;
    end
  end

  // Return FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Return FIFO storage; stale rows are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr_q] <= {ret_last, ret_addr_q, rom_data_i};
  end

  // Outputs forced to zero whenever the FIFO is empty.
  always_comb begin
    busy_o           = (state_q != StIdle);
    done_o           = done_q;
    rom_sprite_sel_o = sel_q;
    rom_word_addr_o  = addr_q;
    word_valid_o     = !fifo_empty;
    word_data_o      = fifo_empty ? 16'd0 : head[15:0];
    word_addr_o      = fifo_empty ? '0 : head[16 +: ADDR_W];
    word_last_o      = !fifo_empty && head[EntryW-1];
  end

  overflow_never: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && fifo_full));

endmodule

// File: tb/tb_sprite_fetch_engine.sv
// Bench for sprite_fetch_engine: a fixed-latency ROM model, a per-fetch
// stream model checked every cycle, and directed scenarios with literal pins.
module tb_sprite_fetch_engine;
  localparam int unsigned LAT   = 3;
  localparam int unsigned WORDS = 1024;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset, start_i, busy_o, done_o;
  logic [2:0]  sprite_i, rom_sprite_sel_o;
  logic [9:0]  rom_word_addr_o, word_addr_o;
  logic [15:0] rom_data_i, word_data_o;
  logic        word_valid_o, word_ready_i, word_last_o;

  always #5 clk = ~clk;

  sprite_fetch_engine #(
    .ROM_LATENCY(LAT),
    .WORDS      (WORDS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .sprite_i        (sprite_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .rom_sprite_sel_o(rom_sprite_sel_o),
    .rom_word_addr_o (rom_word_addr_o),
    .rom_data_i      (rom_data_i),
    .word_valid_o    (word_valid_o),
    .word_ready_i    (word_ready_i),
    .word_data_o     (word_data_o),
    .word_addr_o     (word_addr_o),
    .word_last_o     (word_last_o)
  );

  // ROM contents and fixed-latency ROM responder.
  function automatic logic [15:0] rom_word(input logic [2:0] s, input logic [9:0] a);
    return {s, 3'b101, a};
  endfunction

  logic [15:0] rom_pipe [LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_word(rom_sprite_sel_o, rom_word_addr_o);
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data_i = rom_pipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Stream model: one active fetch, words expected in address order.
  logic        chk_en = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [2:0]  m_sprite = 3'd0;
  int          m_idx = 0;
  int          m_t0 = 0;
  logic        p_stall = 1'b0;
  logic [15:0] p_data;
  logic [9:0]  p_addr;
  logic        p_last;
  int          rmode = 0;
  // Per-fetch observations used for the literal timing pins.
  int          st_first = -1, st_last = -1, st_done = -1, st_n = 0, st_d5 = -1;
  logic        st_busy1 = 1'b0;
  logic [9:0]  st_addr1 = '1;

  // Compare DUT against the model in the middle of every cycle, then advance it.
  always @(negedge clk) begin
    int   rel, outst;
    logic hs, was_busy, nd;
    rel = cyc - m_t0;
    hs  = word_valid_o && word_ready_i;
    if (chk_en) begin
      check("busy_o", 32'(busy_o), 32'(m_busy));
      check("done_o", 32'(done_o), 32'(m_done));
      if (m_busy) begin
        check("rom_sprite_sel_o", 32'(rom_sprite_sel_o), 32'(m_sprite));
        outst = int'(rom_word_addr_o) - m_idx;
        check("credit_bound", 32'(outst <= int'(DEPTH)), 32'd1);
      end else begin
        check("word_valid_o_idle", 32'(word_valid_o), 32'd0);
      end
      if (word_valid_o && p_stall) begin
        check("hold_data", 32'(word_data_o), 32'(p_data));
        check("hold_addr", 32'(word_addr_o), 32'(p_addr));
        check("hold_last", 32'(word_last_o), 32'(p_last));
      end
      if (hs && m_busy) begin
        check("word_addr_o", 32'(word_addr_o), 32'(m_idx));
        check("word_data_o", 32'(word_data_o), 32'(rom_word(m_sprite, m_idx[9:0])));
        check("word_last_o", 32'(word_last_o), 32'(m_idx == int'(WORDS) - 1));
      end
    end
    if (m_busy) begin
      if (rel == 1) begin
        st_busy1 = busy_o;
        st_addr1 = rom_word_addr_o;
      end
      if (word_valid_o && st_first < 0) st_first = rel;
      if (hs) begin
        st_n++;
        if (word_last_o) st_last = rel;
        if (word_addr_o == 10'd5) st_d5 = int'(word_data_o);
      end
    end
    if (done_o) st_done = rel;

    p_stall  = word_valid_o && !word_ready_i && !reset;
    p_data   = word_data_o;
    p_addr   = word_addr_o;
    p_last   = word_last_o;
    was_busy = m_busy;
    nd       = 1'b0;
    if (reset) begin
      m_busy = 1'b0;
      m_idx  = 0;
    end else begin
      if (hs && m_busy) begin
        if (m_idx == int'(WORDS) - 1) begin
          m_busy = 1'b0;
          nd     = 1'b1;
        end
        m_idx++;
      end
      if (!was_busy && start_i && sprite_i != 3'd7) begin
        m_busy   = 1'b1;
        m_sprite = sprite_i;
        m_idx    = 0;
        m_t0     = cyc;
        st_first = -1;
        st_last  = -1;
        st_done  = -1;
        st_n     = 0;
        st_d5    = -1;
      end
    end
    m_done = nd;
  end

  // Downstream ready: always high, a fixed stall window, or random.
  initial begin
    word_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       word_ready_i = 1'b1;
        1:       word_ready_i = !((cyc - m_t0) >= 6 && (cyc - m_t0) <= 25);
        default: word_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fetch(input logic [2:0] s);
    start_i  = 1'b1;
    sprite_i = s;
    tick();
    start_i  = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (done_o !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check("done_within_budget", 32'(done_o), 32'd1);
  endtask

  task automatic wait_rel(input int r);
    while ((cyc - m_t0) < r) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(busy_o), 32'd0);
    check({tag, "_done"},  32'(done_o), 32'd0);
    check({tag, "_valid"}, 32'(word_valid_o), 32'd0);
    check({tag, "_last"},  32'(word_last_o), 32'd0);
    check({tag, "_sel"},   32'(rom_sprite_sel_o), 32'd0);
    check({tag, "_raddr"}, 32'(rom_word_addr_o), 32'd0);
    check({tag, "_data"},  32'(word_data_o), 32'd0);
    check({tag, "_waddr"}, 32'(word_addr_o), 32'd0);
  endtask

  initial begin
    logic [9:0] sv_addr;
    logic [2:0] sv_sel;
    reset    = 1'b1;
    start_i  = 1'b0;
    sprite_i = 3'd0;
    repeat (3) tick();
    check_all_zero("reset");
    chk_en = 1'b1;
    reset  = 1'b0;
    tick();

    // Sprite 2, ready always high: literal timing pins.
    rmode = 0;
    start_fetch(3'd2);
    wait_done(2000);
    tick();
    check("t1_busy_cycle1", 32'(st_busy1), 32'd1);
    check("t1_addr_cycle1", 32'(st_addr1), 32'd0);
    check("t1_first_valid", 32'(st_first), 32'd5);
    check("t1_last_cycle",  32'(st_last), 32'd1028);
    check("t1_done_cycle",  32'(st_done), 32'd1029);
    check("t1_word_count",  32'(st_n), 32'd1024);
    check("t1_word5_data",  32'(st_d5), 32'h5405);

    // Sprite 5 with a 20-cycle stall from cycle 6.
    rmode = 1;
    start_fetch(3'd5);
    wait_rel(10);
    check("t2_addr_frozen_c10", 32'(rom_word_addr_o), 32'd9);
    wait_rel(26);
    check("t2_addr_frozen_c26", 32'(rom_word_addr_o), 32'd9);
    wait_rel(27);
    check("t2_addr_resume_c27", 32'(rom_word_addr_o), 32'd10);
    wait_done(2000);
    tick();
    check("t2_word_count", 32'(st_n), 32'd1024);
    rmode = 0;

    // Random backpressure on sprites 0, 4 and 6.
    foreach (sv_sel[i]) begin end
    for (int k = 0; k < 3; k++) begin
      rmode = 2;
      start_fetch((k == 0) ? 3'd0 : (k == 1) ? 3'd4 : 3'd6);
      wait_done(6000);
      tick();
      check("t3_word_count", 32'(st_n), 32'd1024);
    end
    rmode = 0;

    // Sprite 7 ignored in IDLE; start mid-fetch ignored.
    sv_addr  = rom_word_addr_o;
    sv_sel   = rom_sprite_sel_o;
    start_i  = 1'b1;
    sprite_i = 3'd7;
    repeat (4) tick();
    start_i  = 1'b0;
    check("t4_busy_sprite7", 32'(busy_o), 32'd0);
    check("t4_addr_sprite7", 32'(rom_word_addr_o), 32'(sv_addr));
    check("t4_sel_sprite7",  32'(rom_sprite_sel_o), 32'(sv_sel));
    tick();
    start_fetch(3'd1);
    wait_rel(40);
    start_fetch(3'd3);
    wait_done(2000);
    tick();
    check("t4_word_count", 32'(st_n), 32'd1024);

    // Reset at cycle 300 of a fetch, then a fresh sprite-0 fetch.
    start_fetch(3'd2);
    wait_rel(300);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("t5_after_reset");
    repeat (6) tick();
    start_fetch(3'd0);
    wait_done(2000);
    tick();
    check("t5_first_valid", 32'(st_first), 32'd5);
    check("t5_word_count",  32'(st_n), 32'd1024);

    // Start held high through the done cycle: back-to-back fetches.
    start_i  = 1'b1;
    sprite_i = 3'd4;
    tick();
    sprite_i = 3'd6;
    wait_done(2000);
    tick();
    start_i = 1'b0;
    check("t6_busy_after_done", 32'(busy_o), 32'd1);
    check("t6_sel_second",      32'(rom_sprite_sel_o), 32'd6);
    wait_done(2000);
    tick();
    check("t6_word_count", 32'(st_n), 32'd1024);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
